// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Purpose : shared definitions for the Gray-to-binary conversion scheduler.
//           Holds the FSM state encoding and a constant clog2 helper used to
//           size the bit index counter and the requester index.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package gray_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CONV = ST_CONV,
      DONE = ST_DONE
   } state_e;

   // Ceiling log2 usable in constant expressions; clog2(1) is 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/gray_conv_sched_if.sv
// ---------------------------------------------------------------------------
// gray_conv_sched_if
// Purpose : bundles the requester side and the result side of the shared
//           Gray-to-binary converter.
// Signals : req_valid/req_gray/req_ready - per-requester request handshake
//           out_valid/out_bin/out_id/out_ready - tagged result handshake
//           busy - converter is not idle
// Modports: master - the environment (requesters and consumer)
//           slave  - the converter itself
// ---------------------------------------------------------------------------
interface gray_conv_sched_if #(
   parameter int WIDTH = 3,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) ();

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_gray;
   logic [NREQ-1:0]       req_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_bin;
   logic [IDW-1:0]        out_id;
   logic                  out_ready;
   logic                  busy;

   modport master (
      output req_valid, req_gray, out_ready,
      input  req_ready, out_valid, out_bin, out_id, busy
   );

   modport slave (
      input  req_valid, req_gray, out_ready,
      output req_ready, out_valid, out_bin, out_id, busy
   );

endinterface

// File: rtl/rr_arb_onehot.sv
// ---------------------------------------------------------------------------
// rr_arb_onehot
// Purpose : purely combinational round-robin pick. Starting at ptr_i and
//           wrapping upward, the first asserted request wins.
// Ports   : req_i  - request vector
//           ptr_i  - highest-priority index for this pick
//           gnt_o  - one-hot grant (all zero when no request)
//           idx_o  - encoded index of the granted requester
// ---------------------------------------------------------------------------
module rr_arb_onehot #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o
);

   // Walk the requesters in priority order ptr, ptr+1, ... (mod NREQ) and
   // latch onto the first one that is asking.
   always_comb begin
      logic             found;
      logic [IDW-1:0]   cand;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(ptr_i) + k) % NREQ);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/gray_conv_sched.sv
// ---------------------------------------------------------------------------
// gray_conv_sched
// Purpose : one bit-serial Gray-to-binary converter shared by NREQ
//           requesters. A round-robin arbiter picks a requester in IDLE,
//           the FSM converts its code MSB-first one bit per clock, and the
//           tagged result waits in DONE until the consumer takes it.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - slave side of gray_conv_sched_if (requests, result, busy)
// ---------------------------------------------------------------------------
module gray_conv_sched
   import gray_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   gray_conv_sched_if.slave bus
);

   localparam int IW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

   state_e           state_q;
   logic [IDW-1:0]   rrPtr_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] gray_q;
   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] bin_d;
   logic [IW-1:0]    idx_q;
   logic             outValid_q;
   logic             busy_q;

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   grantIdx;
   logic             accept;
   logic [WIDTH-1:0] grayArr [NREQ];
   logic [WIDTH-1:0] bitSel;
   logic             upperBit;
   logic             newBit;

   rr_arb_onehot #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) uArb (
      .req_i (bus.req_valid),
      .ptr_i (rrPtr_q),
      .gnt_o (gnt),
      .idx_o (grantIdx)
   );

   // Grants are only offered from IDLE; the arbiter only grants asserted
   // requests, so any grant seen in IDLE is an accept.
   assign bus.req_ready = (state_q == IDLE) ? gnt : '0;
   assign accept        = (state_q == IDLE) && (|gnt);

   // Slice the packed request bus into one code per requester so the
   // granted code can be picked by index.
   always_comb begin
      for (int r = 0; r < NREQ; r++) begin
         grayArr[r] = bus.req_gray[r*WIDTH +: WIDTH];
      end
   end

   // One step of the XOR chain: the bit at idx is its Gray bit XORed with the
   // binary bit just above it. Shifting the select mask up by one drops off
   // the top, which supplies the zero seed for the MSB without a special case.
   // bin_q is cleared on accept, so OR-ing in the new bit is enough.
   always_comb begin
      bitSel   = WIDTH'(1) << idx_q;
      upperBit = |(bin_q & (bitSel << 1));
      newBit   = (|(gray_q & bitSel)) ^ upperBit;
      bin_d    = bin_q | (newBit ? bitSel : '0);
   end

   // Main FSM with registered outputs. IDLE captures the granted request and
   // advances the round-robin pointer past it, CONV produces one binary bit
   // per edge from MSB down, DONE holds the tagged result until drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rrPtr_q    <= '0;
         id_q       <= '0;
         gray_q     <= '0;
         bin_q      <= '0;
         idx_q      <= '0;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  gray_q  <= grayArr[grantIdx];
                  bin_q   <= '0;
                  idx_q   <= IW'(WIDTH - 1);
                  id_q    <= grantIdx;
                  rrPtr_q <= (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= CONV;
               end
            end
            CONV: begin
               bin_q <= bin_d;
               if (idx_q == '0) begin
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  outValid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               outValid_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_valid = outValid_q;
   assign bus.out_bin   = bin_q;
   assign bus.out_id    = id_q;
   assign bus.busy      = busy_q;

endmodule
